decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DW, default 32, meaning register-file and operand data width (legal values 32 or 64).
REQ-002 Parameter BYPASS, default 1, meaning 1 = same-cycle write-through of wb_data to read ports, 0 = no bypass.
REQ-003 CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 ifid_valid  input  1  IF/ID entry valid; ifid_instr  input  32  instruction; ifid_pc  input  32  PC+4 of instruction.
REQ-006 ifid_ready  output  1  stage accepts the IF/ID entry this cycle.
REQ-007 wb_en  input  1; wb_addr  input  5; wb_data  input  DW  register write-back port.
REQ-008 flush  input  1  kill the entry being decoded and invalidate ID/EX.
REQ-009 ex_ready  input  1  EX accepts the ID/EX entry this cycle.
REQ-010 idex_valid  output  1; idex_ctrl  output  10; idex_rs_data, idex_rt_data  output  DW; idex_imm  output  DW.
REQ-011 idex_rs, idex_rt, idex_rd, idex_shamt  output  5 each; idex_func  output  6; idex_pc  output  32; idex_illegal  output  1.

Function
REQ-012 Decode fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], func=[5:0], imm=[15:0].
REQ-013 idex_imm SHALL be imm sign-extended to DW.
REQ-014 Control decode: R-type op 000000, lw 100011, sw 101011, beq 000100, j 000010; ctrl[9:0] = regdst, alusrc, aluop1, aluop0, branch, jump, memread, memwrite, regwrite, memtoreg.
REQ-015 R: regdst=aluop1=regwrite=1; lw: alusrc=memread=regwrite=memtoreg=1; sw: alusrc=memwrite=1; beq: aluop0=branch=1; j: jump=1; all other bits 0.
REQ-016 Any other opcode: ctrl=0, idex_illegal=1 on that entry.
REQ-017 Register file: 32 entries x DW; register 0 reads 0 always; writes to address 0 ignored.
REQ-018 Write occurs at the clock edge when wb_en=1 and wb_addr!=0.
REQ-019 BYPASS=1: a read of address A!=0 with wb_en=1, wb_addr=A in the same cycle returns wb_data; BYPASS=0: returns the old value.
REQ-020 advance = ~idex_valid | ex_ready.
REQ-021 hazard = idex_valid & idex_ctrl[3] & (idex_rt!=0) & (idex_rt==rs | idex_rt==rt) (load-use).
REQ-022 ifid_ready = advance & ~hazard & ~flush (combinational).
REQ-023 On an edge with advance=1: if ifid_valid & ifid_ready, ID/EX loads the decoded entry and idex_valid=1; otherwise ID/EX loads a bubble (idex_valid=0, idex_ctrl=0).
REQ-024 On an edge with advance=0 and flush=0, all idex_* outputs hold their values.
REQ-025 flush=1 forces idex_valid=0 and idex_ctrl=0 at the next edge, regardless of advance or hazard.
REQ-026 Hazard stalls last exactly one cycle per load: the bubble clears the hazard, and the held IF/ID entry is then accepted.
REQ-027 Register writes proceed independently of stall, flush and ex_ready.
REQ-028 Latency: an accepted instruction appears on idex_* one cycle after acceptance.

Reset
REQ-029 With RST=1 at an edge, all 32 registers are set to 0; idex_valid, idex_ctrl, idex_illegal and all idex_* data/field outputs are set to 0.
REQ-030 RST overrides wb_en, flush and ifid_valid in the same cycle; ifid_ready=0 while RST=1.
REQ-031 A reset asserted during a stall discards the stalled entry; the first cycle after reset has advance=1.

Verification
REQ-032 Reset, then write r5=0x1234 via WB; decode add r3,r5,r0 (0x00A01820) -> idex_rs_data=0x1234, idex_rt_data=0, idex_ctrl=0x282, idex_valid=1.
REQ-033 wb_en=1, wb_addr=7, wb_data=0xCAFE in the same cycle as decoding sw r7,-4(r0) (0xAC07FFFC): BYPASS=1 -> idex_rt_data=0xCAFE, BYPASS=0 -> old r7; both cases -> idex_imm=0xFFFFFFFC, idex_ctrl=0x104.
REQ-034 Decode lw r2,0(r1) followed by add r4,r2,r3 -> one bubble cycle (idex_valid=0, ifid_ready=0), then the add enters ID/EX; the same add with rs=r0 target (lw r0) -> no bubble.
REQ-035 ex_ready=0 for 3 cycles with idex_valid=1 -> idex_* stable, ifid_ready=0; flush in the 2nd cycle -> idex_valid=0 at the next edge.
REQ-036 Opcode 111111 -> idex_illegal=1, idex_ctrl=0; wb_addr=0, wb_data=0xFFFF -> subsequent read of r0 returns 0; RST asserted with wb_en=1 -> written register reads 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// IF/ID -> ID/EX handshake bundle for the decode stage, plus the write-back port.
// The slave side is the decode stage; the master side is the surrounding pipeline.
interface decode_stage_if #(
  parameter int DW = 32
) ();
  logic          ifid_valid;
  logic [31:0]   ifid_instr;
  logic [31:0]   ifid_pc;
  logic          ifid_ready;

  logic          wb_en;
  logic [4:0]    wb_addr;
  logic [DW-1:0] wb_data;

  logic          flush;
  logic          ex_ready;

  logic          idex_valid;
  logic [9:0]    idex_ctrl;
  logic [DW-1:0] idex_rs_data;
  logic [DW-1:0] idex_rt_data;
  logic [DW-1:0] idex_imm;
  logic [4:0]    idex_rs;
  logic [4:0]    idex_rt;
  logic [4:0]    idex_rd;
  logic [4:0]    idex_shamt;
  logic [5:0]    idex_func;
  logic [31:0]   idex_pc;
  logic          idex_illegal;

  modport slave (
    input  ifid_valid, ifid_instr, ifid_pc,
    output ifid_ready,
    input  wb_en, wb_addr, wb_data,
    input  flush, ex_ready,
    output idex_valid, idex_ctrl, idex_rs_data, idex_rt_data, idex_imm,
    output idex_rs, idex_rt, idex_rd, idex_shamt, idex_func, idex_pc, idex_illegal
  );

  modport master (
    output ifid_valid, ifid_instr, ifid_pc,
    input  ifid_ready,
    output wb_en, wb_addr, wb_data,
    output flush, ex_ready,
    input  idex_valid, idex_ctrl, idex_rs_data, idex_rt_data, idex_imm,
    input  idex_rs, idex_rt, idex_rd, idex_shamt, idex_func, idex_pc, idex_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS-style decode stage: field split, control decode, 32-entry register file
// with optional write-through, load-use interlock and the ID/EX pipeline register.
module decode_stage #(
  parameter int DW     = 32,
  parameter int BYPASS = 1
) (
  input  logic          CLK,
  input  logic          RST,
  decode_stage_if.slave bus
);

  localparam logic [5:0] OP_R  = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J  = 6'b000010;
  localparam bit         BYP   = (BYPASS != 0);

  // ctrl bit order: regdst alusrc aluop1 aluop0 branch jump memread memwrite regwrite memtoreg
  function automatic logic [10:0] decode_ctrl(input logic [5:0] op);
    logic [10:0] r;
    r = '0;
    case (op)
      OP_R:    r[9:0] = 10'b1010000010;
      OP_LW:   r[9:0] = 10'b0100001011;
      OP_SW:   r[9:0] = 10'b0100000100;
      OP_BEQ:  r[9:0] = 10'b0001100000;
      OP_J:    r[9:0] = 10'b0000010000;
      default: r[10]  = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic signed [DW-1:0] sext16(input logic signed [15:0] v);
    return DW'(v);
  endfunction

  logic [DW-1:0] rf [32];

  // ---- stage 0: combinational decode and operand read ----
  logic [5:0]           op_p0;
  logic [4:0]           rs_p0, rt_p0, rd_p0, shamt_p0;
  logic [5:0]           func_p0;
  logic signed [DW-1:0] imm_p0;
  logic [10:0]          dec_p0;
  logic [DW-1:0]        rs_data_p0, rt_data_p0;

  assign op_p0    = bus.ifid_instr[31:26];
  assign rs_p0    = bus.ifid_instr[25:21];
  assign rt_p0    = bus.ifid_instr[20:16];
  assign rd_p0    = bus.ifid_instr[15:11];
  assign shamt_p0 = bus.ifid_instr[10:6];
  assign func_p0  = bus.ifid_instr[5:0];
  assign imm_p0   = sext16(bus.ifid_instr[15:0]);
  assign dec_p0   = decode_ctrl(op_p0);

  // Register 0 is hardwired; write-through only when the write would actually land.
  always_comb begin
    rs_data_p0 = '0;
    rt_data_p0 = '0;
    if (rs_p0 != 5'd0) begin
      rs_data_p0 = rf[rs_p0];
      if (BYP && bus.wb_en && (bus.wb_addr == rs_p0)) rs_data_p0 = bus.wb_data;
    end
    if (rt_p0 != 5'd0) begin
      rt_data_p0 = rf[rt_p0];
      if (BYP && bus.wb_en && (bus.wb_addr == rt_p0)) rt_data_p0 = bus.wb_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  // ---- stage 1: ID/EX register ----
  logic                 vld_p1;
  logic [9:0]           ctrl_p1;
  logic                 illegal_p1;
  logic [DW-1:0]        rs_data_p1, rt_data_p1;
  logic signed [DW-1:0] imm_p1;
  logic [4:0]           rs_p1, rt_p1, rd_p1, shamt_p1;
  logic [5:0]           func_p1;
  logic [31:0]          pc_p1;

  logic advance, hazard, accept;

  // Load-use: the load in ID/EX (memread) targets a register this instruction reads.
  assign advance = ~vld_p1 | bus.ex_ready;
  assign hazard  = vld_p1 & ctrl_p1[3] & (rt_p1 != 5'd0) &
                   ((rt_p1 == rs_p0) | (rt_p1 == rt_p0));
  assign bus.ifid_ready = ~RST & advance & ~hazard & ~bus.flush;
  assign accept  = bus.ifid_valid & bus.ifid_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1     <= 1'b0;
      ctrl_p1    <= '0;
      illegal_p1 <= 1'b0;
      rs_data_p1 <= '0;
      rt_data_p1 <= '0;
      imm_p1     <= '0;
      rs_p1      <= '0;
      rt_p1      <= '0;
      rd_p1      <= '0;
      shamt_p1   <= '0;
      func_p1    <= '0;
      pc_p1      <= '0;
    end else if (bus.flush || (advance && !accept)) begin
      vld_p1     <= 1'b0;
      ctrl_p1    <= '0;
      illegal_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1     <= 1'b1;
      ctrl_p1    <= dec_p0[9:0];
      illegal_p1 <= dec_p0[10];
      rs_data_p1 <= rs_data_p0;
      rt_data_p1 <= rt_data_p0;
      imm_p1     <= imm_p0;
      rs_p1      <= rs_p0;
      rt_p1      <= rt_p0;
      rd_p1      <= rd_p0;
      shamt_p1   <= shamt_p0;
      func_p1    <= func_p0;
      pc_p1      <= bus.ifid_pc;
    end
  end

  assign bus.idex_valid   = vld_p1;
  assign bus.idex_ctrl    = ctrl_p1;
  assign bus.idex_illegal = illegal_p1;
  assign bus.idex_rs_data = rs_data_p1;
  assign bus.idex_rt_data = rt_data_p1;
  assign bus.idex_imm     = imm_p1;
  assign bus.idex_rs      = rs_p1;
  assign bus.idex_rt      = rt_p1;
  assign bus.idex_rd      = rd_p1;
  assign bus.idex_shamt   = shamt_p1;
  assign bus.idex_func    = func_p1;
  assign bus.idex_pc      = pc_p1;

endmodule
